fpmult_norm_stage: RTL

Pipelined normalization stage of the single-precision floating-point multiplier. It sits directly upstream of the rounding stage. It takes the raw 48-bit mantissa product and the biased exponent sum from the multiply stage, then performs the one-bit normalization shift, bias removal and guard/round/sticky extraction. It delivers NormM/NormE/G/R/S through a two-register pipeline with a valid/ready handshake.

---
 rtl/fpmult_pkg.sv | 47 ++++
 rtl/fpmult_norm_shift.sv | 32 +++
 rtl/fpmult_norm_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fpmult_pkg.sv
// Shared types and constants for the single-precision multiplier normalization path.
package fpmult_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned PROD_W   = 48;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned EXP_W    = 9;
  localparam int unsigned ESUM_W   = 10;

  // Internal unbiased-exponent width; wide enough for 0-127 .. 510-127+1 with sign.
  localparam int unsigned EX_W     = 11;

  // Largest biased exponent that still denotes a finite normal number, plus one.
  localparam int signed   EXP_OVF  = 255;

  // Normalized result fields as delivered to the rounding stage.
  typedef struct packed {
    logic [FRAC_W-1:0] norm_m;
    logic [EXP_W-1:0]  norm_e;
    logic              g;
    logic              r;
    logic              s;
    logic              zero;
  } norm_t;

  // Stage-1 contents: shifted product fields plus the raw exponent sum.
  typedef struct packed {
    logic              hi;
    logic [FRAC_W-1:0] frac;
    logic              r;
    logic              g;
    logic              s;
    logic              zero;
    logic [ESUM_W-1:0] esum;
  } stage1_t;

  // Remove one bias from the exponent sum and add the normalization carry, full width.
  function automatic logic signed [EX_W-1:0] unbias(input logic [ESUM_W-1:0] esum,
                                                    input logic              hi);
    logic signed [EX_W-1:0] sum_ext;
    logic signed [EX_W-1:0] hi_ext;
    sum_ext = $signed({1'b0, esum});
    hi_ext  = $signed({{(EX_W - 1){1'b0}}, hi});
    return sum_ext - $signed(EX_W'(EXP_BIAS)) + hi_ext;
  endfunction

endpackage

// File: rtl/fpmult_norm_shift.sv
// Combinational one-bit normalization of a 24x24 mantissa product: picks the
// fraction window from the product MSB and extracts round/guard/sticky and zero.
module fpmult_norm_shift
  import fpmult_pkg::*;
(
  input  logic [PROD_W-1:0] prod_i,
  output logic              hi_o,
  output logic [FRAC_W-1:0] frac_o,
  output logic              r_o,
  output logic              g_o,
  output logic              s_o,
  output logic              zero_o
);

  // Product in [2,4) shifts right one extra place; in [1,2) the window starts one lower.
  always_comb begin
    hi_o   = prod_i[47];
    zero_o = (prod_i == '0);
    if (prod_i[47]) begin
      frac_o = prod_i[46:24];
      r_o    = prod_i[23];
      g_o    = prod_i[22];
      s_o    = |prod_i[21:0];
    end else begin
      frac_o = prod_i[45:23];
      r_o    = prod_i[22];
      g_o    = prod_i[21];
      s_o    = |prod_i[20:0];
    end
  end

endmodule

// File: rtl/fpmult_norm_stage.sv
// Two-register normalization stage of the FP multiplier with valid/ready flow control.
// Stage 1 captures the shifted product fields, stage 2 removes the exponent bias.
// Optional macro FPMULT_NORM_EXC_EN adds registered overflow/underflow flags; without
// it Ovf and Unf are constant 0.
module fpmult_norm_stage
  import fpmult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [PROD_W-1:0] Prod,
  input  logic [ESUM_W-1:0] ESum,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [FRAC_W-1:0] NormM,
  output logic [EXP_W-1:0]  NormE,
  output logic              R,
  output logic              G,
  output logic              S,
  output logic              Zero,
  output logic              Ovf,
  output logic              Unf
);

  logic    v1_q, v1_d;
  logic    v2_q, v2_d;
  logic    ld1, ld2, accept;
  stage1_t s1_d, s1_q;
  norm_t   s2_d, s2_q;

  fpmult_norm_shift u_shift (
    .prod_i (Prod),
    .hi_o   (s1_d.hi),
    .frac_o (s1_d.frac),
    .r_o    (s1_d.r),
    .g_o    (s1_d.g),
    .s_o    (s1_d.s),
    .zero_o (s1_d.zero)
  );

  assign s1_d.esum = ESum;

  // Stall control: a stage loads when it is empty or the stage after it moves.
  // OutReady reaches InReady combinationally so a full pipe can still stream.
  always_comb begin
    ld2     = !v2_q || OutReady;
    ld1     = !v1_q || ld2;
    InReady = ld1;
    accept  = InValid && ld1;
    v1_d    = ld1 ? InValid : v1_q;
    v2_d    = ld2 ? v1_q : v2_q;
  end

  // Valid bits are the only reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  // Stage-1 data register, loaded only on an accepted offer.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_q <= s1_d;
    end
  end

  // Stage-2 next state: bias removal; a zero product clears every numeric field.
  always_comb begin
    s2_d        = '0;
    s2_d.zero   = s1_q.zero;
    if (!s1_q.zero) begin
      s2_d.norm_m = s1_q.frac;
      s2_d.norm_e = EXP_W'(unbias(s1_q.esum, s1_q.hi));
      s2_d.g      = s1_q.g;
      s2_d.r      = s1_q.r;
      s2_d.s      = s1_q.s;
    end
  end

  // Stage-2 data register; holds while the downstream stalls.
  always_ff @(posedge clk) begin
    if (ld2 && v1_q) begin
      s2_q <= s2_d;
    end
  end

`ifdef FPMULT_NORM_EXC_EN
  logic signed [EX_W-1:0] ex;
  logic                   ovf_d, ovf_q;
  logic                   unf_d, unf_q;

  // Range checks use the full signed exponent so negative results are caught.
  always_comb begin
    ex    = unbias(s1_q.esum, s1_q.hi);
    ovf_d = (ex >= EX_W'(EXP_OVF)) && !s1_q.zero;
    unf_d = (ex <= '0) && !s1_q.zero;
  end

  // Exception flags travel with the stage-2 data.
  always_ff @(posedge clk) begin
    if (ld2 && v1_q) begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign Ovf = v2_q & ovf_q;
  assign Unf = v2_q & unf_q;
`else
  assign Ovf = 1'b0;
  assign Unf = 1'b0;
`endif

  // Outputs read zero whenever no result is presented.
  always_comb begin
    OutValid = v2_q;
    NormM    = v2_q ? s2_q.norm_m : '0;
    NormE    = v2_q ? s2_q.norm_e : '0;
    R        = v2_q & s2_q.r;
    G        = v2_q & s2_q.g;
    S        = v2_q & s2_q.s;
    Zero     = v2_q & s2_q.zero;
  end

endmodule
